// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a hold limit that forces rotation
// when other requesters are waiting. All outputs are registered.
module rr_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(MAX_HOLD);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_HOLD - 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e          state_q;
  logic [1:0]      owner_q;
  logic [1:0]      ptr_q;
  logic [CntW-1:0] hold_q;
  logic [3:0]      gnt_q;
  logic            busy_q;

  logic [3:0] owner_oh;
  logic [3:0] other_req;
  logic       idle_found;
  logic [1:0] idle_w;
  logic       rot_found;
  logic [1:0] rot_w;
  logic       rearb;

  function automatic logic [3:0] decode(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Returns {found, index} of the first set bit scanning upward from start.
  function automatic logic [2:0] search(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    owner_oh              = decode(owner_q);
    other_req             = req & ~owner_oh;
    {idle_found, idle_w}  = search(req, ptr_q);
    // The current owner is excluded, so a releasing owner cannot win again here.
    {rot_found, rot_w}    = search(other_req, owner_q + 2'd1);
    rearb                 = ~req[owner_q] | ((hold_q == CntMax) & (|other_req));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      owner_q <= 2'd0;
      ptr_q   <= 2'd0;
      hold_q  <= '0;
      gnt_q   <= 4'b0000;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (idle_found) begin
            state_q <= StGrant;
            owner_q <= idle_w;
            ptr_q   <= idle_w + 2'd1;
            hold_q  <= '0;
            gnt_q   <= decode(idle_w);
            busy_q  <= 1'b1;
          end
        end
        StGrant: begin
          if (rearb) begin
            if (rot_found) begin
              owner_q <= rot_w;
              ptr_q   <= rot_w + 2'd1;
              hold_q  <= '0;
              gnt_q   <= decode(rot_w);
            end else begin
              // owner_q is kept so gnt_idx still shows the last owner.
              state_q <= StIdle;
              gnt_q   <= 4'b0000;
              busy_q  <= 1'b0;
            end
          end else if (hold_q != CntMax) begin
            hold_q <= hold_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = owner_q;
  assign busy    = busy_q;

  a_gnt_onehot0: assert property (@(posedge clk) $onehot0(gnt));
  a_gnt_decode:  assert property (@(posedge clk) gnt == (busy ? decode(gnt_idx) : 4'b0000));

endmodule

// File: doc/rr_arbiter_4.md
# rr_arbiter_4

Four-requester round-robin arbiter that shares one resource slot among requesters 0-3. It produces a registered owner index `gnt_idx` and its one-hot 2-to-4 decoded form `gnt`, so only one requester drives the shared datapath at a time. A hold limit forces rotation when other requesters are waiting. It sits between the request sources and the 2x4 decode/select stage of the shared datapath.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles one owner keeps the grant while another request is pending. Legal range 2..256.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; one clock, reset is synchronous and active-high.
- `req` in 4: `req[i]` high means requester i wants the resource; it is level-sensitive and held until the requester is done.
- `gnt` out 4: one-hot grant; `gnt[i]` high means requester i owns the resource; all zero when idle. Always equals decode(`gnt_idx`) gated by `busy`.
- `gnt_idx` out 2: binary index of the current owner; holds the last owner when idle.
- `busy` out 1: high while any grant is active.

## Operation
- State: FSM {IDLE, GRANT}; `owner` (2b, drives `gnt_idx`); `ptr` (2b, next search start); `hold_cnt` (width clog2(MAX_HOLD), saturating at MAX_HOLD-1).
- Reset values: state IDLE, `gnt`=0000, `gnt_idx`=0, `busy`=0, `ptr`=0, `hold_cnt`=0. Reset overrides `req` and any grant in progress.
- Search(start, mask): the first index i in start, start+1, ... (mod 4) with `req[i]` & mask[i]. This is combinational.
- IDLE:
  - If `req`==0, stay in IDLE.
  - Otherwise w = Search(`ptr`, 1111). Go to GRANT with `owner`=w, `hold_cnt`=0, `ptr`=w+1 mod 4.
- GRANT, owner o:
  - release = `req[o]`==0.
  - preempt = `hold_cnt`==MAX_HOLD-1 and (`req` & ~onehot(o))!=0.
  - If release or preempt: w = Search(o+1, ~onehot(o)).
    - If w exists: `owner`=w, `hold_cnt`=0, `ptr`=w+1, stay in GRANT.
    - If no w exists: go to IDLE, `gnt`=0000, `busy`=0, `gnt_idx` keeps o.
  - Otherwise: stay, and `hold_cnt` increments with saturation.
- A lone owner is never preempted. The counter saturates and the grant is held indefinitely.
- Handoff between owners is direct, with no idle cycle inserted.
- `gnt` has at most one bit set in every cycle. This is checked by an assertion.

## Timing
- Request-to-grant latency is 1 cycle. A `req` sampled at edge n gives `gnt` at edge n+1 (from IDLE or at a handoff).
- Release-to-clear latency is 1 cycle. When the owner's `req` drops before edge n, `gnt` changes at edge n.
- Hold window: the grant is held for exactly MAX_HOLD cycles when contended, counted from the grant edge. Preemption occurs at the edge where `hold_cnt`=MAX_HOLD-1.
- Simultaneous release and preempt are treated identically (one rearbitration).
- If the owner re-asserts `req` in the same cycle it releases, it is excluded from that search. It can win again only if no other requester is pending, in which case it wins via IDLE one cycle later.
- Reset during GRANT: `gnt`=0000 at the edge where `reset` is sampled high.
- All outputs are registered, with no combinational path from `req` to `gnt`.

## Test plan
- Reset with `req`=1111 held for 3 cycles: `gnt`=0000 and `busy`=0 throughout. At the first edge after `reset` drops, `gnt`=0001 and `gnt_idx`=0.
- Single requester: `req`=0100 for 5 cycles, then 0000. Expect `gnt`=0100 one cycle after assertion and held 5 cycles, then `gnt`=0000 and `busy`=0 one cycle after the drop.
- Fairness, MAX_HOLD=8, `req`=1111 constant: `gnt_idx` sequence 0,1,2,3,0, each owner held exactly 8 cycles, with no gap cycles.
- Release handoff: owner 1 drops `req` while `req[0]`=`req[3]`=1. Next edge `gnt`=1000 (search starts at 2), then 0001 after owner 3 releases.
- No lone preemption: `req`=0001 held 20 cycles with MAX_HOLD=4. `gnt` stays 0001 all 20 cycles. Raise `req[2]`: `gnt`=0100 within one cycle.
- Reset mid-grant: owner 2 is active and `reset` is pulsed for 1 cycle. `gnt`=0000 at that edge, then after reset `gnt`=0001 if `req`=0101 (`ptr` restored to 0).
